// File: rtl/i2s_pkg.sv
// Purpose : Shared definitions for the I2S receiver and transmitter.
// Contents: default sample width, channel encoding on lrclk and the
//           output-buffer state encoding.
package i2s_pkg;

    // Default bits per PCM sample per channel.
    localparam int I2S_DATA_WIDTH_DEFAULT = 16;

    // Channel selected by lrclk (word select).
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Output buffer state: EMPTY drives pcm_valid low, FULL drives it high.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage : i2s_pkg

// File: rtl/i2s_sync_edge.sv
// Purpose : Brings one asynchronous input into the clk domain through a
//           SYNC_STAGES-deep flop chain and registers the result once more
//           so a rising edge can be detected.
// Ports   : clk, rst_n   - system clock, async active-low reset
//           i_async      - asynchronous input
//           o_sync       - synchronized level
//           o_rise       - one-cycle pulse: synchronized level is 1, previous 0
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain followed by the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : i2s_sync_edge

// File: rtl/i2s_receiver.sv
// Purpose : I2S slave receiver. Deserializes left/right words from an
//           external bclk/lrclk/sd stream (MSB first, one-bit lrclk delay),
//           pairs them and hands each stereo pair to a consumer through a
//           valid/ready buffer with a sticky overrun flag.
// Ports   : clk, rst_n            - system clock, async active-low reset
//           i2s_bclk/lrclk/sd     - asynchronous I2S inputs
//           pcm_left/pcm_right    - delivered stereo pair
//           pcm_valid/pcm_ready   - pair handshake
//           overrun / overrun_clr - sticky "pair dropped" flag and its clear
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = I2S_DATA_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sd,
    output logic [DATA_WIDTH-1:0] pcm_left,
    output logic [DATA_WIDTH-1:0] pcm_right,
    output logic                  pcm_valid,
    input  logic                  pcm_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int            CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    // Synchronized inputs
    logic w_bclk_sync;
    logic w_bclk_rise;
    logic w_lr_sync;
    logic w_lr_rise_unused;
    logic w_sd_sync;
    logic w_sd_rise_unused;

    // Deserializer state
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  r_left_held;
    logic                  r_lr_prev;

    // Completed pair, valid for one cycle
    logic [DATA_WIDTH-1:0] r_pair_left;
    logic [DATA_WIDTH-1:0] r_pair_right;
    logic                  r_pair_vld;

    // Output buffer
    out_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_pcm_left;
    logic [DATA_WIDTH-1:0] r_pcm_right;
    logic                  r_pcm_valid;
    logic                  r_overrun;

    // Next-bit datapath
    logic [CW-1:0]         w_cnt_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_lr_change;
    logic                  w_drop;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i2s_bclk),
        .o_sync  (w_bclk_sync),
        .o_rise  (w_bclk_rise)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i2s_lrclk),
        .o_sync  (w_lr_sync),
        .o_rise  (w_lr_rise_unused)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i2s_sd),
        .o_sync  (w_sd_sync),
        .o_rise  (w_sd_rise_unused)
    );

    // Shift/count result of the current bclk edge; bits past DATA_WIDTH are ignored.
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_bit_cnt;
        if (w_bclk_rise && (r_bit_cnt < CNT_FULL)) begin
            w_shift_next = {r_shift[DATA_WIDTH-2:0], w_sd_sync};
            w_cnt_next   = r_bit_cnt + CNT_ONE;
        end else begin
            w_shift_next = r_shift;
            w_cnt_next   = r_bit_cnt;
        end
    end

    // Short words are left-aligned: the missing LSBs come out as zero.
    assign w_word      = w_shift_next << (CNT_FULL - w_cnt_next);
    assign w_lr_change = w_bclk_rise & (w_lr_sync != r_lr_prev);
    assign w_drop      = (r_state == ST_FULL) & r_pair_vld & ~pcm_ready;

    // Deserializer: accumulate bits, commit a word on each lrclk change and pair left with right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= CNT_ZERO;
            r_shift      <= {DATA_WIDTH{1'b0}};
            r_left_hold  <= {DATA_WIDTH{1'b0}};
            r_left_held  <= 1'b0;
            r_lr_prev    <= LEFT;
            r_pair_left  <= {DATA_WIDTH{1'b0}};
            r_pair_right <= {DATA_WIDTH{1'b0}};
            r_pair_vld   <= 1'b0;
        end else begin
            r_pair_vld <= 1'b0;
            if (w_lr_change) begin
                r_bit_cnt <= CNT_ZERO;
                r_shift   <= {DATA_WIDTH{1'b0}};
                r_lr_prev <= w_lr_sync;
                // A word with no bits before the change edge has no slot behind
                // it (e.g. the first bclk edge after reset with lrclk high):
                // it is discarded and breaks any pending pairing.
                if (r_bit_cnt == CNT_ZERO) begin
                    r_left_held <= 1'b0;
                end else if (r_lr_prev == LEFT) begin
                    r_left_hold <= w_word;
                    r_left_held <= 1'b1;
                end else if (r_left_held) begin
                    r_pair_left  <= r_left_hold;
                    r_pair_right <= w_word;
                    r_pair_vld   <= 1'b1;
                    r_left_held  <= 1'b0;
                end else begin
                    r_left_held <= 1'b0;
                end
            end else if (w_bclk_rise) begin
                r_bit_cnt <= w_cnt_next;
                r_shift   <= w_shift_next;
            end else begin
                r_bit_cnt <= r_bit_cnt;
                r_shift   <= r_shift;
            end
        end
    end

    // Output buffer FSM with sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_pcm_valid <= 1'b0;
            r_pcm_left  <= {DATA_WIDTH{1'b0}};
            r_pcm_right <= {DATA_WIDTH{1'b0}};
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_drop | (r_overrun & ~overrun_clr);
            case (r_state)
                ST_EMPTY: begin
                    if (r_pair_vld) begin
                        r_pcm_left  <= r_pair_left;
                        r_pcm_right <= r_pair_right;
                        r_pcm_valid <= 1'b1;
                        r_state     <= ST_FULL;
                    end else begin
                        r_pcm_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pcm_ready && r_pair_vld) begin
                        // Consumer takes the old pair while the new one lands.
                        r_pcm_left  <= r_pair_left;
                        r_pcm_right <= r_pair_right;
                        r_pcm_valid <= 1'b1;
                        r_state     <= ST_FULL;
                    end else if (pcm_ready) begin
                        r_pcm_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else begin
                        // Held pair stays stable; any arriving pair is dropped.
                        r_pcm_valid <= 1'b1;
                        r_state     <= ST_FULL;
                    end
                end
                default: begin
                    r_pcm_valid <= 1'b0;
                    r_state     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign pcm_left  = r_pcm_left;
    assign pcm_right = r_pcm_right;
    assign pcm_valid = r_pcm_valid;
    assign overrun   = r_overrun;

endmodule : i2s_receiver

// File: tb/tb_i2s_receiver.sv
`timescale 1ns/1ps
module tb_i2s_receiver;
    import i2s_pkg::*;

    localparam int DW     = 16;
    localparam int SYNC_A = 2;
    localparam int SYNC_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;   // 100 MHz

    logic          rst_n;
    logic          bclk;
    logic          lrclk;
    logic          sd;
    logic          ready_a;
    logic          ovr_clr;
    logic [DW-1:0] left_a, right_a, left_b, right_b;
    logic          valid_a, valid_b, ovr_a, ovr_b;

    i2s_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC_A)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2s_bclk    (bclk),
        .i2s_lrclk   (lrclk),
        .i2s_sd      (sd),
        .pcm_left    (left_a),
        .pcm_right   (right_a),
        .pcm_valid   (valid_a),
        .pcm_ready   (ready_a),
        .overrun     (ovr_a),
        .overrun_clr (ovr_clr)
    );

    i2s_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC_B)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2s_bclk    (bclk),
        .i2s_lrclk   (lrclk),
        .i2s_sd      (sd),
        .pcm_left    (left_b),
        .pcm_right   (right_b),
        .pcm_valid   (valid_b),
        .pcm_ready   (1'b1),
        .overrun     (ovr_b),
        .overrun_clr (ovr_clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int pairs_a  = 0;
    int pairs_b  = 0;
    logic prev_valid_a = 1'b0;
    logic prev_valid_b = 1'b0;
    logic [2*DW-1:0] q_a[$];
    logic [2*DW-1:0] q_b[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard side for the SYNC_STAGES=2 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid_a = 1'b0;
        end else begin
            if (valid_a && !prev_valid_a)
                check_value("latency_a", cyc - rise_cyc, SYNC_A + 2);
            if (valid_a && ready_a) begin
                pairs_a++;
                check_value("pair_a_expected", (q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    logic [2*DW-1:0] e;
                    e = q_a.pop_front();
                    check_value("left_a", left_a, e[2*DW-1:DW]);
                    check_value("right_a", right_a, e[DW-1:0]);
                end
            end
            prev_valid_a = valid_a;
        end
    end

    // Scoreboard side for the SYNC_STAGES=3 instance (always ready).
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid_b = 1'b0;
        end else begin
            if (valid_b && !prev_valid_b)
                check_value("latency_b", cyc - rise_cyc, SYNC_B + 2);
            if (valid_b) begin
                pairs_b++;
                check_value("pair_b_expected", (q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    logic [2*DW-1:0] e;
                    e = q_b.pop_front();
                    check_value("left_b", left_b, e[2*DW-1:DW]);
                    check_value("right_b", right_b, e[DW-1:0]);
                end
            end
            prev_valid_b = valid_b;
        end
    end

    // One bclk period = 8 clk; data and lrclk change on the falling edge.
    task automatic send_bit(input logic lr, input logic b, input int pulse_at);
        bclk  = 1'b0;
        lrclk = lr;
        sd    = b;
        repeat (4) @(posedge clk);
        #1;
        bclk     = 1'b1;
        rise_cyc = cyc;
        for (int c = 0; c < 4; c++) begin
            if (c == pulse_at) ready_a = 1'b1;
            @(posedge clk);
            #1;
            if (c == pulse_at) ready_a = 1'b0;
        end
    endtask

    // Bits hi..lo of a word for channel ch; lrclk flips on bit 0 (one-bit delay).
    task automatic send_bits(input logic ch, input logic [31:0] val, input int hi, input int lo,
                             input int lsb_pulse);
        for (int i = hi; i >= lo; i--)
            send_bit((i == 0) ? ~ch : ch, val[i], (i == 0) ? lsb_pulse : -1);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int w);
        send_bits(LEFT, l, w - 1, 0, -1);
        send_bits(RIGHT, r, w - 1, 0, -1);
    endtask

    task automatic push_both(input logic [DW-1:0] l, input logic [DW-1:0] r);
        q_a.push_back({l, r});
        q_b.push_back({l, r});
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++)
            @(posedge clk);
        #1;
        check_value({tag, "_drain_a"}, q_a.size(), 0);
        check_value({tag, "_drain_b"}, q_b.size(), 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; sd = 1'b0; ready_a = 1'b0; ovr_clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_value("rst_valid_a", valid_a, 0);
        check_value("rst_left_a", left_a, 0);
        check_value("rst_right_a", right_a, 0);
        check_value("rst_ovr_a", ovr_a, 0);
        check_value("rst_valid_b", valid_b, 0);
        check_value("rst_left_b", left_b, 0);
        check_value("rst_ovr_b", ovr_b, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Basic frame, preceded by a partial right word that must not surface.
        ready_a = 1'b1;
        send_bits(RIGHT, 32'h0000_000F, 7, 0, -1);
        check_value("partial_frame_dropped", pairs_a, 0);
        push_both(16'hA5C3, 16'h0F0F);
        send_frame(32'h0000_A5C3, 32'h0000_0F0F, 16);
        wait_drain("basic");
        check_value("basic_pairs_a", pairs_a, 1);

        // Consumer stalls across two frames: first pair held, second dropped.
        ready_a = 1'b0;
        q_a.push_back({16'h1111, 16'h2222});
        q_b.push_back({16'h1111, 16'h2222});
        q_b.push_back({16'h3333, 16'h4444});
        send_frame(32'h0000_1111, 32'h0000_2222, 16);
        send_frame(32'h0000_3333, 32'h0000_4444, 16);
        repeat (8) @(posedge clk);
        #1;
        check_value("hold_valid_a", valid_a, 1);
        check_value("hold_left_a", left_a, 16'h1111);
        check_value("hold_right_a", right_a, 16'h2222);
        check_value("ovr_set_a", ovr_a, 1);
        check_value("ovr_clear_b", ovr_b, 0);
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;
        check_value("accept_valid_a", valid_a, 0);
        check_value("ovr_sticky_a", ovr_a, 1);
        ovr_clr = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr = 1'b0;
        check_value("ovr_cleared_a", ovr_a, 0);
        ready_a = 1'b1;
        wait_drain("stall");

        // Long slots are truncated, short slots left-aligned.
        push_both(16'h1234, 16'h6543);
        send_frame(32'h0012_3456, 32'h0065_4321, 24);
        push_both(16'hABC0, 16'h1230);
        send_frame(32'h0000_0ABC, 32'h0000_0123, 12);
        wait_drain("width");

        // Ready pulses exactly when the next pair lands: swap, stay FULL.
        ready_a = 1'b0;
        push_both(16'h5555, 16'hAAAA);
        push_both(16'h1357, 16'h2468);
        send_frame(32'h0000_5555, 32'h0000_AAAA, 16);
        send_bits(LEFT, 32'h0000_1357, 15, 0, -1);
        send_bits(RIGHT, 32'h0000_2468, 15, 0, SYNC_A + 1);
        check_value("swap_valid_a", valid_a, 1);
        check_value("swap_left_a", left_a, 16'h1357);
        check_value("swap_right_a", right_a, 16'h2468);
        check_value("swap_ovr_a", ovr_a, 0);
        ready_a = 1'b1;
        wait_drain("swap");

        // Reset mid-right-word with a pair held in the stalled instance.
        ready_a = 1'b0;
        q_b.push_back({16'h0101, 16'h0202});
        send_frame(32'h0000_0101, 32'h0000_0202, 16);
        send_bits(LEFT, 32'h0000_7777, 15, 0, -1);
        send_bits(RIGHT, 32'h0000_9999, 15, 8, -1);
        check_value("pre_rst_valid_a", valid_a, 1);
        rst_n = 1'b0;
        bclk  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_value("mid_rst_valid_a", valid_a, 0);
        check_value("mid_rst_left_a", left_a, 0);
        check_value("mid_rst_right_a", right_a, 0);
        check_value("mid_rst_left_b", left_b, 0);
        check_value("mid_rst_right_b", right_b, 0);
        rst_n   = 1'b1;
        ready_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        p0 = pairs_a;
        send_bits(RIGHT, 32'h0000_9999, 7, 0, -1);
        repeat (8) @(posedge clk);
        #1;
        check_value("post_rst_no_pair_a", pairs_a - p0, 0);
        push_both(16'h8888, 16'h9999);
        send_frame(32'h0000_8888, 32'h0000_9999, 16);
        wait_drain("reset");
        check_value("post_rst_pair_a", pairs_a - p0, 1);
        check_value("final_ovr_a", ovr_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_i2s_receiver

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per PCM sample per channel (legal range 8..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop count of each input synchronizer (legal range 2..3).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge; one clock domain only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i2s_bclk  input  1  external bit clock, asynchronous to clk, frequency at most clk/4.
REQ-006 SHALL have port i2s_lrclk  input  1  external word select, asynchronous (0 = left, 1 = right).
REQ-007 SHALL have port i2s_sd  input  1  external serial data, MSB first.
REQ-008 SHALL have port pcm_left  output  DATA_WIDTH  left sample of the delivered stereo pair.
REQ-009 SHALL have port pcm_right  output  DATA_WIDTH  right sample of the delivered stereo pair.
REQ-010 SHALL have port pcm_valid  output  1  the stereo pair is held and valid.
REQ-011 SHALL have port pcm_ready  input  1  consumer accepts the pair.
REQ-012 SHALL have port overrun  output  1  sticky flag: a completed pair was dropped.
REQ-013 SHALL have port overrun_clr  input  1  clears overrun, synchronous, single-cycle effect.

Function
REQ-014 SHALL pass i2s_bclk, i2s_lrclk and i2s_sd through SYNC_STAGES-deep synchronizers, then register each once more for edge detection.
REQ-015 SHALL generate one-cycle bclk_rise when the synchronized bclk is 1 and its previous value is 0; all protocol actions occur only in cycles where bclk_rise is 1.
REQ-016 On each bclk_rise, if bit_cnt < DATA_WIDTH, SHALL shift the synchronized sd into the LSB of the shift register and increment bit_cnt; otherwise the bit is ignored (slot longer than DATA_WIDTH is truncated).
REQ-017 On a bclk_rise where the synchronized lrclk differs from lr_prev (the lrclk value at the previous bclk_rise), SHALL first apply REQ-016, then commit the word to the channel given by lr_prev, then clear bit_cnt and the shift register, then update lr_prev.
REQ-018 With REQ-017, the MSB is the first bclk_rise after the lrclk change, and the LSB is the bclk_rise at which the next change is seen (standard I2S one-bit delay).
REQ-019 A committed word with bit_cnt < DATA_WIDTH SHALL be left-aligned, with the (DATA_WIDTH - bit_cnt) LSBs set to 0.
REQ-020 A committed word with bit_cnt = 0 SHALL be discarded and SHALL clear left_held.
REQ-021 A left commit SHALL load left_hold and set left_held.
REQ-022 A right commit with left_held = 1 SHALL form a pair and clear left_held.
REQ-023 A right commit with left_held = 0 SHALL be discarded; therefore the first partial frame after reset is never delivered.
REQ-024 Output FSM states: EMPTY (pcm_valid = 0) and FULL (pcm_valid = 1).
REQ-025 In EMPTY, a pair SHALL load pcm_left/pcm_right and transition to FULL.
REQ-026 In FULL, the cycle with pcm_ready = 1 SHALL transition to EMPTY.
REQ-027 In FULL, a pair arriving in the same cycle as pcm_ready = 1 SHALL be loaded and the FSM SHALL stay FULL.
REQ-028 In FULL, a pair arriving with pcm_ready = 0 SHALL be dropped, leaving the outputs unchanged, and SHALL set overrun.
REQ-029 pcm_left/pcm_right SHALL be stable while pcm_valid = 1 and pcm_ready = 0.
REQ-030 pcm_valid SHALL rise exactly SYNC_STAGES+2 clk cycles after the i2s_bclk rising edge that carries the right-channel LSB, assuming the inputs meet setup time to clk.
REQ-031 If overrun_clr and a new drop occur in the same cycle, overrun SHALL be 1 (set wins).
REQ-032 lrclk changes between bclk edges SHALL have no effect until the next bclk_rise.

Reset
REQ-033 While rst_n = 0, SHALL force pcm_valid = 0, pcm_left = 0, pcm_right = 0, overrun = 0, bit_cnt = 0, shift register = 0, left_held = 0, lr_prev = 0, and all synchronizer/edge flops = 0.
REQ-034 A reset asserted mid-word or mid-handshake SHALL discard all partial and held data; after release, REQ-023 governs.

Structure
REQ-035 Package i2s_pkg SHALL hold the DATA_WIDTH default, the channel constants LEFT = 0 and RIGHT = 1, and the output FSM state encoding, shared with the transmitter.
REQ-036 The synchronizer plus edge detector SHALL be one sub-module, i2s_sync_edge, instantiated for bclk, lrclk and sd (rise output used for bclk only).

Verification
REQ-037 Bench SHALL drive clk = 100 MHz with bclk = clk/8, 16-bit slots, left 0xA5C3 and right 0x0F0F -> one pair pcm_left = 0xA5C3, pcm_right = 0x0F0F; the first partial frame is not delivered.
REQ-038 Bench SHALL hold pcm_ready = 0 across two full frames -> first pair held stable, overrun = 1; pulse overrun_clr -> overrun = 0.
REQ-039 Bench SHALL send 24-bit slots with left 0x123456 -> pcm_left = 0x1234; send 12-bit slots with 0xABC -> pcm_left = 0xABC0.
REQ-040 Bench SHALL assert pcm_ready = 1 at the same time a new pair completes -> new pair loaded, pcm_valid stays 1, no overrun.
REQ-041 Bench SHALL assert rst_n = 0 mid-right-word, then release -> all outputs 0; the next frame's left word completes before any pair is delivered.
REQ-042 Bench SHALL check pcm_valid latency = SYNC_STAGES+2 clk cycles from the i2s_bclk edge carrying the right-channel LSB, for SYNC_STAGES = 2 and SYNC_STAGES = 3.
